keypad_scanner: RTL and testbench

- Reads a 4x4 active-low key matrix, the input-side counterpart of the multiplexed anode-scan display driver.
- Drives one column low at a time and samples the rows.
- Debounces across whole scans and reports a single debounced key press as a code plus a one-cycle strobe.
- Sits between board keypad pins and the control/display logic.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scan_timer.sv | 43 ++++
 rtl/keypad_scanner.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, scan-result and FSM state types for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  // Number of closed (low) row lines in one column sample.
  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      n = n + {2'b00, ~v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column dwell timer: holds each column low for SCAN_DIV cycles and flags the
// row sample point and the end of a full four-column scan.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic [NUM_COLS-1:0] o_col,
  output logic [1:0]          o_col_idx,
  output logic                o_sample_stb,
  output logic                o_scan_end
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx;
  logic          w_dwell_last;

  assign w_dwell_last = (r_dwell == DWELL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell   <= '0;
      r_col_idx <= '0;
    end else if (w_dwell_last) begin
      r_dwell   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_dwell   <= r_dwell + DW'(1);
    end
  end

  // Sampling on the last dwell cycle gives the rows the longest settle time.
  assign o_col        = ~(NUM_COLS'(1) << r_col_idx);
  assign o_col_idx    = r_col_idx;
  assign o_sample_stb = w_dwell_last;
  assign o_scan_end   = w_dwell_last && (r_col_idx == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row synchronizer, per-scan closure
// accumulator and a scan-level debounce FSM producing a press code and strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic                multi_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [1:0]          w_col_idx;
  logic                w_sample_stb;
  logic                w_scan_end;

  logic [NUM_ROWS-1:0] r_row_s1;
  logic [NUM_ROWS-1:0] r_row_s2;
  logic [1:0]          r_acc_cnt;
  logic [3:0]          r_acc_code;

  key_state_e          r_state;
  logic [3:0]          r_cand;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_key_code;
  logic                r_key_valid;
  logic                r_key_down;
  logic                r_multi_key;

  logic [2:0]          w_low_cnt;
  logic [1:0]          w_low_sat;
  logic [2:0]          w_total;
  logic [1:0]          w_hit_row;
  logic [3:0]          w_acc_code_nxt;
  logic [1:0]          w_acc_cnt_nxt;
  scan_res_e           w_res;
  logic [CNT_W-1:0]    w_cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= DEB_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [1:0] sat_two(input logic [2:0] v);
    return (v > 3'd1) ? 2'd2 : v[1:0];
  endfunction

  keypad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .o_col        (col),
    .o_col_idx    (w_col_idx),
    .o_sample_stb (w_sample_stb),
    .o_scan_end   (w_scan_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  // Closure count saturates at 2: only none / one / many matters.
  always_comb begin
    w_low_cnt = count_low(r_row_s2);
    w_low_sat = sat_two(w_low_cnt);
    w_total   = {1'b0, r_acc_cnt} + {1'b0, w_low_sat};
    w_hit_row = 2'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!r_row_s2[i]) w_hit_row = 2'(i);
    end
    w_acc_code_nxt = (w_low_cnt == 3'd1) ? {w_hit_row, w_col_idx} : r_acc_code;
    w_acc_cnt_nxt  = sat_two(w_total);
    case (w_acc_cnt_nxt)
      2'd0:    w_res = RES_NONE;
      2'd1:    w_res = RES_SINGLE;
      default: w_res = RES_MULTI;
    endcase
    w_cnt_inc = sat_inc(r_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_cnt  <= '0;
      r_acc_code <= '0;
    end else if (w_scan_end) begin
      r_acc_cnt  <= '0;
      r_acc_code <= '0;
    end else if (w_sample_stb) begin
      r_acc_cnt  <= w_acc_cnt_nxt;
      r_acc_code <= w_acc_code_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_end) begin
        r_multi_key <= (w_res == RES_MULTI);
        case (r_state)
          ST_IDLE: begin
            if (w_res == RES_SINGLE) begin
              r_cand <= w_acc_code_nxt;
              if (DEBOUNCE_SCANS == 1) begin
                r_key_code  <= w_acc_code_nxt;
                r_key_down  <= 1'b1;
                r_key_valid <= 1'b1;
                r_cnt       <= '0;
                r_state     <= ST_PRESSED;
              end else begin
                r_cnt       <= CNT_W'(1);
                r_state     <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if ((w_res == RES_SINGLE) && (w_acc_code_nxt == r_cand)) begin
              if (w_cnt_inc == DEB_MAX) begin
                r_key_code  <= r_cand;
                r_key_down  <= 1'b1;
                r_key_valid <= 1'b1;
                r_cnt       <= '0;
                r_state     <= ST_PRESSED;
              end else begin
                r_cnt       <= w_cnt_inc;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (w_res == RES_NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                r_key_down <= 1'b0;
                r_cnt      <= '0;
                r_state    <= ST_IDLE;
              end else begin
                r_cnt      <= CNT_W'(1);
                r_state    <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (w_res == RES_NONE) begin
              if (w_cnt_inc == DEB_MAX) begin
                r_key_down <= 1'b0;
                r_cnt      <= '0;
                r_state    <= ST_IDLE;
              end else begin
                r_cnt      <= w_cnt_inc;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= ST_PRESSED;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 and a
// behavioural 4x4 switch matrix driving the row lines from the column drive.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        multi_key;

  logic [15:0] keys;
  int          n_checks;
  int          n_errors;
  int          vcnt;
  int          wide;
  logic        prev_v;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .multi_key (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid) vcnt++;
    if (key_valid && prev_v) wide++;
    prev_v = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_up(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!key_down) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"},   col,       4'b1110);
    chk({tag, "_code"},  key_code,  4'h0);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_down"},  key_down,  1'b0);
    chk({tag, "_multi"}, multi_key, 1'b0);
  endtask

  initial begin
    int         lat;
    int         v0;
    logic [3:0] exp_col;
    logic [3:0] one;

    n_checks = 0;
    n_errors = 0;
    vcnt     = 0;
    wide     = 0;
    prev_v   = 1'b0;
    keys     = 16'h0000;
    reset    = 1'b0;
    one      = 4'b0001;

    #1;
    chk_reset_outputs("rst0");
    cycles(2);
    chk("rst_hold_col", col, 4'b1110);

    // Idle scan: column walk 1110,1101,1011,0111, four cycles each.
    #2 reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_col = ~(one << ((k / 4) % 4));
      chk("idle_col", col, exp_col);
    end
    #1;
    chk("idle_no_valid", vcnt, 0);
    chk("idle_down", key_down, 1'b0);

    // Clean press of row1/col2.
    keys[6] = 1'b1;
    wait_valid(67, lat);
    chk("press_seen", lat > 0, 1'b1);
    chk("press_code", key_code, 4'h6);
    chk("press_down", key_down, 1'b1);
    @(negedge clk);
    chk("press_width", key_valid, 1'b0);
    cycles(48);
    #1;
    chk("press_single_pulse", vcnt, 1);

    // Second key while pressed: multi flagged, code held, no rollover.
    keys[0] = 1'b1;
    cycles(32);
    #1;
    chk("pmulti_flag", multi_key, 1'b1);
    chk("pmulti_code", key_code, 4'h6);
    chk("pmulti_down", key_down, 1'b1);
    chk("pmulti_no_valid", vcnt, 1);
    keys[0] = 1'b0;
    cycles(32);
    #1;
    chk("pmulti_clear", multi_key, 1'b0);
    chk("pmulti_still_down", key_down, 1'b1);
    chk("pmulti_no_valid2", vcnt, 1);

    // Release debounce.
    keys[6] = 1'b0;
    cycles(30);
    chk("rel_early_down", key_down, 1'b1);
    wait_up(50, lat);
    chk("rel_seen", lat > 0, 1'b1);
    #1;
    chk("rel_no_valid", vcnt, 1);

    // Bounce: alternate closed/open whole scans, then hold.
    for (int b = 0; b < 4; b++) begin
      keys[6] = 1'b1;
      cycles(16);
      keys[6] = 1'b0;
      cycles(16);
    end
    #1;
    chk("bounce_no_valid", vcnt, 1);
    chk("bounce_down", key_down, 1'b0);
    keys[6] = 1'b1;
    wait_valid(67, lat);
    chk("bounce_press_seen", lat > 0, 1'b1);
    chk("bounce_code", key_code, 4'h6);
    keys[6] = 1'b0;
    wait_up(80, lat);
    chk("bounce_release", lat > 0, 1'b1);

    // Two keys from idle: multi only, never a press.
    #1 v0 = vcnt;
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    cycles(32);
    #1;
    chk("imulti_flag", multi_key, 1'b1);
    chk("imulti_down", key_down, 1'b0);
    cycles(48);
    #1;
    chk("imulti_no_valid", vcnt, v0);
    keys[0]  = 1'b0;
    keys[15] = 1'b0;
    cycles(32);
    chk("imulti_clear", multi_key, 1'b0);

    // Async reset mid-DEBOUNCE, key left closed.
    keys[6] = 1'b1;
    cycles(20);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("rst_deb");
    cycles(2);
    #2 reset = 1'b1;
    wait_valid(67, lat);
    chk("rst_deb_latency", lat, 48);
    chk("rst_deb_code", key_code, 4'h6);
    chk("rst_deb_down", key_down, 1'b1);

    // Async reset mid-PRESSED.
    cycles(10);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("rst_prs");
    cycles(2);
    #2 reset = 1'b1;
    wait_valid(67, lat);
    chk("rst_prs_latency", lat, 48);
    chk("rst_prs_code", key_code, 4'h6);
    keys[6] = 1'b0;
    cycles(4);
    #1;
    chk("valid_width_all", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
